race_ctl: RTL and testbench
===========================

Name: race_ctl

Overview:
- Game sequencer for the drag race.
- Takes start and per-player accelerator levels (from the keyboard interface) plus a slow tick strobe.
- Runs the start-light countdown, integrates each player's speed into track position, and detects false starts, finish and winner.
- Its position outputs drive the background scroll and car-draw stages; its light code drives the start-lights draw stage.

Parameters:
- LIGHT_TICKS, 10, ticks each countdown light stays lit.
- TRACK_LEN, 4096, position at which a player has finished.
- SPEED_MAX, 15, speed saturation value.
- DECAY_TICKS, 4, ticks between automatic speed decrements.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- tick  in  1  one-cycle enable strobe; all timing advances only on tick=1.
- start  in  1  level; begins a race from IDLE or FINISH.
- key_p1  in  1  player 1 accelerator level.
- key_p2  in  1  player 2 accelerator level.
- state  out  2  0 IDLE, 1 COUNTDOWN, 2 RACE, 3 FINISH.
- lights  out  3  0 off, 1..3 red lights lit, 4 green.
- pos_p1  out  16  player 1 position, 0..TRACK_LEN.
- pos_p2  out  16  player 2 position, 0..TRACK_LEN.
- speed_p1  out  4  player 1 current speed.
- speed_p2  out  4  player 2 current speed.
- winner  out  2  0 none, 1 P1, 2 P2, 3 tie.
- false_start  out  2  bit0 P1 disqualified, bit1 P2 disqualified.
- race_time  out  16  ticks elapsed in RACE; saturates at 0xFFFF.

Behaviour:
- Reset (reset=0 at a clk edge): all outputs 0, state IDLE, internal counters 0, edge registers 0. Reset mid-race aborts immediately.
- Key edges: key_p1/key_p2/start are registered each clk. A rising edge is prev=0 and cur=1. Edges are detected every clk, independent of tick, and are held pending until the next tick consumes them.
- IDLE:
  - Outputs hold.
  - start rising edge -> COUNTDOWN: lights=1, light counter=0; clear pos, speed, winner, false_start, race_time.
- COUNTDOWN:
  - Each tick increments the light counter.
  - When the counter reaches LIGHT_TICKS-1: counter=0, lights increments 1->2->3.
  - When leaving lights=3: lights=4, state=RACE.
  - Transitions are registered, so outputs change the clk after the qualifying tick.
- RACE, per tick, per player:
  - Pending accel edge: speed=min(speed+1, SPEED_MAX).
  - Otherwise, if the decay counter hits DECAY_TICKS-1 and speed>0: speed-=1.
  - Accel and decay on the same tick: accel wins and the decay counter still wraps.
  - pos = min(pos+speed, TRACK_LEN), computed on the old speed value.
  - race_time increments.
  - lights returns to 0 after LIGHT_TICKS ticks of RACE.
- Finish:
  - On the tick where pos_p1 or pos_p2 first equals TRACK_LEN, state goes to FINISH.
  - winner=1 or 2 for the sole finisher; 3 if both reach TRACK_LEN on the same tick.
- FINISH:
  - All outputs frozen.
  - start rising edge re-enters COUNTDOWN exactly as from IDLE.
- Width rules: positions are 16-bit unsigned; the sum is computed at 17 bits before saturation. TRACK_LEN must be ≤ 65535.
- A disqualified player's speed is forced to 0 and stays 0.

Optional Feature:
- Macro RACE_CTL_FALSE_START_EN.
- Defined:
  - A player's accel rising edge while in COUNTDOWN sets that player's false_start bit.
  - A single false start immediately (clk after the tick) gives state=FINISH, winner = the other player, lights=0.
  - Both players on the same tick -> winner=3.
- Undefined:
  - Accel edges during COUNTDOWN are discarded.
  - false_start is tied to 0.

Decomposition:
- Package race_pkg holds:
  - state encoding constants: ST_IDLE, ST_COUNTDOWN, ST_RACE, ST_FINISH.
  - winner codes: WIN_NONE, WIN_P1, WIN_P2, WIN_TIE.
  - light codes: LIGHT_OFF, LIGHT_GREEN.
- Sub-module race_player, instantiated twice, contains:
  - edge detect with pending flag,
  - speed saturate/decay,
  - position integrate/saturate,
  - disqualify input.
- race_ctl holds the FSM, light counter, race_time and winner resolution.

Test Plan:
- Reset: hold reset=0 with keys toggling -> all outputs 0 and state=0; release, pulse start, then 10 ticks -> lights=2, state=1.
- Countdown: LIGHT_TICKS=10, start edge -> lights 1/2/3 for 10 ticks each; on tick 30 -> state=2, lights=4; 10 ticks later -> lights=0.
- Accel and decay: P1 gives 3 edges on consecutive ticks -> speed_p1=3. After 4 idle ticks -> speed_p1=2. 20 edges -> speed saturates at 15.
- Finish and tie:
  - TRACK_LEN=64, both players driven identically -> both pos=64 on the same tick, winner=3, state=3.
  - P1 one edge ahead -> winner=1, pos_p1=64 exactly (saturated).
- False start (RACE_CTL_FALSE_START_EN defined): P2 edge at lights=2 -> false_start=2'b10, winner=1, state=3. Same stimulus with the macro undefined -> ignored, race proceeds to state=2.
- Restart and abort:
  - From FINISH, a start edge -> positions, winner and race_time cleared, lights=1.
  - reset=0 asserted mid-RACE -> outputs 0 on the next clk.

Source files
------------

// File: rtl/race_ctl_pkg.sv
// race_pkg: shared state, winner and light codes for the drag race sequencer
package race_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_COUNTDOWN, ST_RACE, ST_FINISH} state_t;
  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1 = 2'd1;
  localparam logic [1:0] WIN_P2 = 2'd2;
  localparam logic [1:0] WIN_TIE = 2'd3;
  localparam logic [2:0] LIGHT_OFF = 3'd0;
  localparam logic [2:0] LIGHT_GREEN = 3'd4;
  function automatic logic [15:0] sat_pos(input logic [16:0] sum, input logic [15:0] lim);
    return (sum >= {1'b0, lim}) ? lim : sum[15:0];
  endfunction
endpackage

// File: rtl/race_ctl_if.sv
// race_ctl_if: tick/start/accelerator inputs and game-state outputs of the race sequencer
interface race_ctl_if import race_pkg::*; ();
  logic tick, start, key_p1, key_p2;
  state_t state;
  logic [2:0] lights;
  logic [15:0] pos_p1, pos_p2, race_time;
  logic [3:0] speed_p1, speed_p2;
  logic [1:0] winner, false_start;
  modport master (output tick, start, key_p1, key_p2,
                  input state, lights, pos_p1, pos_p2, speed_p1, speed_p2, winner, false_start, race_time);
  modport slave (input tick, start, key_p1, key_p2,
                 output state, lights, pos_p1, pos_p2, speed_p1, speed_p2, winner, false_start, race_time);
endinterface

// File: rtl/race_ctl_player.sv
// race_player: one lane's accelerator edge capture, speed saturate/decay and position integration
module race_player import race_pkg::*; #(
  parameter int TRACK_LEN = 4096,
  parameter int SPEED_MAX = 15,
  parameter int DECAY_TICKS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_i,
  input  logic        key_i,
  input  logic        clr_i,
  input  logic        run_i,
  input  logic        dq_i,
  output logic        acc_o,
  output logic        done_o,
  output logic [3:0]  speed_o,
  output logic [15:0] pos_o
);
  logic cur_q, prev_q, pend_q, pend_d, hit, step, dec;
  logic [3:0] spd_q, spd_d;
  logic [15:0] pos_q, pos_d, pos_sat;
  logic [7:0] dcnt_q, dcnt_d;
  assign hit = (cur_q & ~prev_q) | pend_q;
  assign acc_o = tick_i & hit;
  assign step = tick_i & run_i;
  assign dec = dcnt_q == 8'(DECAY_TICKS - 1);
  // the position advances on the speed held before this tick's update
  assign pos_sat = sat_pos({1'b0, pos_q} + 17'(spd_q), 16'(TRACK_LEN));
  assign done_o = step & (pos_sat == 16'(TRACK_LEN));
  assign speed_o = spd_q;
  assign pos_o = pos_q;
  always_comb begin
    pend_d = (clr_i | tick_i) ? 1'b0 : hit;
    dcnt_d = clr_i ? '0 : !step ? dcnt_q : dec ? '0 : dcnt_q + 8'd1;
    pos_d = clr_i ? '0 : step ? pos_sat : pos_q;
    spd_d = (clr_i | dq_i) ? '0 : !step ? spd_q
          : acc_o ? ((spd_q == 4'(SPEED_MAX)) ? spd_q : spd_q + 4'd1)
          : (dec && spd_q != '0) ? spd_q - 4'd1 : spd_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_q <= 1'b0;
      prev_q <= 1'b0;
      pend_q <= 1'b0;
      spd_q <= '0;
      pos_q <= '0;
      dcnt_q <= '0;
    end else begin
      cur_q <= key_i;
      prev_q <= cur_q;
      pend_q <= pend_d;
      spd_q <= spd_d;
      pos_q <= pos_d;
      dcnt_q <= dcnt_d;
    end
  end
endmodule

// File: rtl/race_ctl.sv
// race_ctl: drag race sequencer (start lights, two lanes, finish/winner resolution).
// Define RACE_CTL_FALSE_START_EN to disqualify accelerator presses made during the countdown.
module race_ctl import race_pkg::*; #(
  parameter int LIGHT_TICKS = 10,
  parameter int TRACK_LEN = 4096,
  parameter int SPEED_MAX = 15,
  parameter int DECAY_TICKS = 4
) (
  input logic clk,
  input logic reset,
  race_ctl_if.slave bus
);
`ifdef RACE_CTL_FALSE_START_EN
  localparam logic [1:0] FS_MASK = 2'b11;
`else
  localparam logic [1:0] FS_MASK = 2'b00;
`endif
  localparam logic [7:0] LAST = 8'(LIGHT_TICKS - 1);
  state_t state_q, state_d;
  logic [2:0] lights_q, lights_d;
  logic [7:0] lcnt_q, lcnt_d;
  logic [1:0] win_q, win_d, fs_q, fs_d, acc, done, fs_now;
  logic [15:0] rt_q, rt_d;
  logic st_cur_q, st_prev_q, go, run;
  assign go = st_cur_q & ~st_prev_q & (state_q == ST_IDLE || state_q == ST_FINISH);
  assign run = state_q == ST_RACE;
  assign fs_now = acc & FS_MASK;
  race_player #(.TRACK_LEN(TRACK_LEN), .SPEED_MAX(SPEED_MAX), .DECAY_TICKS(DECAY_TICKS)) u_p1 (
    .clk(clk), .reset(reset), .tick_i(bus.tick), .key_i(bus.key_p1), .clr_i(go), .run_i(run),
    .dq_i(fs_q[0]), .acc_o(acc[0]), .done_o(done[0]), .speed_o(bus.speed_p1), .pos_o(bus.pos_p1));
  race_player #(.TRACK_LEN(TRACK_LEN), .SPEED_MAX(SPEED_MAX), .DECAY_TICKS(DECAY_TICKS)) u_p2 (
    .clk(clk), .reset(reset), .tick_i(bus.tick), .key_i(bus.key_p2), .clr_i(go), .run_i(run),
    .dq_i(fs_q[1]), .acc_o(acc[1]), .done_o(done[1]), .speed_o(bus.speed_p2), .pos_o(bus.pos_p2));
  assign bus.state = state_q;
  assign bus.lights = lights_q;
  assign bus.winner = win_q;
  assign bus.false_start = fs_q;
  assign bus.race_time = rt_q;
  always_comb begin
    state_d = state_q;
    lights_d = lights_q;
    lcnt_d = lcnt_q;
    win_d = win_q;
    fs_d = fs_q;
    rt_d = rt_q;
    if (go) begin
      state_d = ST_COUNTDOWN;
      lights_d = 3'd1;
      lcnt_d = '0;
      win_d = WIN_NONE;
      fs_d = '0;
      rt_d = '0;
    end else if (bus.tick && state_q == ST_COUNTDOWN) begin
      lcnt_d = (lcnt_q == LAST) ? '0 : lcnt_q + 8'd1;
      lights_d = (lcnt_q == LAST) ? lights_q + 3'd1 : lights_q;
      state_d = (lcnt_q == LAST && lights_q == 3'd3) ? ST_RACE : ST_COUNTDOWN;
      if (fs_now != '0) begin
        state_d = ST_FINISH;
        lights_d = LIGHT_OFF;
        fs_d = fs_now;
        win_d = (fs_now == 2'b11) ? WIN_TIE : fs_now[0] ? WIN_P2 : WIN_P1;
      end
    end else if (bus.tick && run) begin
      rt_d = (rt_q == 16'hFFFF) ? rt_q : rt_q + 16'd1;
      // the light counter is reused to time how long green stays lit
      lcnt_d = (lights_q != LIGHT_GREEN || lcnt_q == LAST) ? '0 : lcnt_q + 8'd1;
      lights_d = (lights_q == LIGHT_GREEN && lcnt_q == LAST) ? LIGHT_OFF : lights_q;
      if (done != '0) begin
        state_d = ST_FINISH;
        win_d = (done == 2'b11) ? WIN_TIE : done[0] ? WIN_P1 : WIN_P2;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      lights_q <= LIGHT_OFF;
      lcnt_q <= '0;
      win_q <= WIN_NONE;
      fs_q <= '0;
      rt_q <= '0;
      st_cur_q <= 1'b0;
      st_prev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lights_q <= lights_d;
      lcnt_q <= lcnt_d;
      win_q <= win_d;
      fs_q <= fs_d;
      rt_q <= rt_d;
      st_cur_q <= bus.start;
      st_prev_q <= st_cur_q;
    end
  end
endmodule

// File: tb/tb_race_ctl.sv
// tb_race_ctl: directed scoreboard bench for race_ctl with a per-tick behavioural reference
module tb_race_ctl;
  import race_pkg::*;
  localparam int LT = 10, TL = 256, SM = 15, DT = 4;
`ifdef RACE_CTL_FALSE_START_EN
  localparam bit FS_EN = 1'b1;
`else
  localparam bit FS_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  race_ctl_if bus();
  race_ctl #(.LIGHT_TICKS(LT), .TRACK_LEN(TL), .SPEED_MAX(SM), .DECAY_TICKS(DT)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int m_state, m_lights, m_lcnt, m_win, m_fs, m_rt;
  int sp[2], pos[2], dc[2];
  bit pend[2];
  logic [64:0] sb[$];

  function automatic logic [64:0] snap_dut();
    return {2'(bus.state), bus.lights, bus.pos_p1, bus.pos_p2, bus.speed_p1, bus.speed_p2,
            bus.winner, bus.false_start, bus.race_time};
  endfunction
  function automatic logic [64:0] snap_model();
    return {2'(m_state), 3'(m_lights), 16'(pos[0]), 16'(pos[1]), 4'(sp[0]), 4'(sp[1]),
            2'(m_win), 2'(m_fs), 16'(m_rt)};
  endfunction
  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic sb_check(input string tag);
    logic [64:0] e;
    e = sb.pop_front();
    check(tag, snap_dut(), e);
  endtask

  task automatic model_reset();
    m_state = 0; m_lights = 0; m_lcnt = 0; m_win = 0; m_fs = 0; m_rt = 0;
    for (int i = 0; i < 2; i++) begin sp[i] = 0; pos[i] = 0; dc[i] = 0; pend[i] = 0; end
  endtask
  task automatic model_start();
    if (m_state == 0 || m_state == 3) begin
      model_reset();
      m_state = 1;
      m_lights = 1;
    end
  endtask
  task automatic lane(input int i, input bit a);
    pos[i] = (pos[i] + sp[i] > TL) ? TL : pos[i] + sp[i];
    if (a) sp[i] = (sp[i] < SM) ? sp[i] + 1 : SM;
    else if (dc[i] == DT - 1 && sp[i] > 0) sp[i]--;
    dc[i] = (dc[i] == DT - 1) ? 0 : dc[i] + 1;
  endtask
  task automatic model_tick();
    bit a1, a2;
    a1 = pend[0]; a2 = pend[1];
    pend[0] = 0; pend[1] = 0;
    if (m_state == 1) begin
      if (FS_EN && (a1 || a2)) begin
        m_fs = (a2 ? 2 : 0) + (a1 ? 1 : 0);
        m_state = 3;
        m_lights = 0;
        m_win = (a1 && a2) ? 3 : (a1 ? 2 : 1);
      end else if (m_lcnt == LT - 1) begin
        m_lcnt = 0;
        m_lights++;
        if (m_lights == 4) m_state = 2;
      end else m_lcnt++;
    end else if (m_state == 2) begin
      lane(0, a1);
      lane(1, a2);
      if (m_rt < 65535) m_rt++;
      if (m_lights == 4) begin
        if (m_lcnt == LT - 1) begin m_lcnt = 0; m_lights = 0; end
        else m_lcnt++;
      end
      if (pos[0] == TL || pos[1] == TL) begin
        m_state = 3;
        m_win = (pos[0] == TL && pos[1] == TL) ? 3 : (pos[0] == TL ? 1 : 2);
      end
    end
  endtask

  task automatic press(input bit k1, input bit k2);
    bus.key_p1 = k1; bus.key_p2 = k2;
    repeat (3) @(negedge clk);
    bus.key_p1 = 1'b0; bus.key_p2 = 1'b0;
    repeat (2) @(negedge clk);
    if (k1) pend[0] = 1;
    if (k2) pend[1] = 1;
  endtask
  task automatic do_tick(input string tag);
    bus.tick = 1'b1;
    model_tick();
    sb.push_back(snap_model());
    @(negedge clk);
    bus.tick = 1'b0;
    sb_check(tag);
  endtask
  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) do_tick(tag);
  endtask
  task automatic do_start();
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    model_start();
    sb.push_back(snap_model());
    sb_check("start");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.tick = 1'b0; bus.start = 1'b0; bus.key_p1 = 1'b0; bus.key_p2 = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.key_p1 = ~bus.key_p1; bus.key_p2 = i[0]; bus.start = ~bus.start; bus.tick = ~bus.tick;
    end
    @(negedge clk);
    sb.push_back(snap_model());
    sb_check("reset");
    bus.key_p1 = 1'b0; bus.key_p2 = 1'b0; bus.start = 1'b0; bus.tick = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    do_start();
    check("lights1", 65'(bus.lights), 65'(1));
    ticks(10, "cd_a");
    check("lights2", 65'(bus.lights), 65'(2));
    check("state_cd", 65'(bus.state), 65'(1));
    ticks(20, "cd_b");
    check("go_state", 65'(bus.state), 65'(2));
    check("go_lights", 65'(bus.lights), 65'(4));
    ticks(10, "green");
    check("lights_off", 65'(bus.lights), 65'(0));

    for (int i = 0; i < 3; i++) begin press(1, 0); do_tick("accel"); end
    check("speed3", 65'(bus.speed_p1), 65'(3));
    ticks(4, "decay");
    check("speed_decay", 65'(bus.speed_p1), 65'(2));
    for (int i = 0; i < 20; i++) begin press(1, 0); do_tick("accel20"); end
    check("speed_sat", 65'(bus.speed_p1), 65'(15));
    for (int i = 0; i < 10 && m_state != 3; i++) do_tick("to_finish");
    check("p1_state", 65'(bus.state), 65'(3));
    check("p1_winner", 65'(bus.winner), 65'(1));
    check("p1_pos_sat", 65'(bus.pos_p1), 65'(TL));
    press(1, 1);
    do_tick("frozen");

    do_start();
    check("restart_pos", 65'({bus.pos_p1, bus.pos_p2, bus.winner, bus.race_time}), 65'(0));
    check("restart_lights", 65'(bus.lights), 65'(1));
    ticks(30, "cd_tie");
    for (int i = 0; i < 40 && m_state != 3; i++) begin press(1, 1); do_tick("tie_run"); end
    check("tie_winner", 65'(bus.winner), 65'(3));
    check("tie_state", 65'(bus.state), 65'(3));
    check("tie_pos", 65'({bus.pos_p1, bus.pos_p2}), 65'({16'(TL), 16'(TL)}));

    do_start();
    ticks(10, "cd_fs");
    check("fs_lights2", 65'(bus.lights), 65'(2));
    press(0, 1);
    do_tick("fs_tick");
`ifdef RACE_CTL_FALSE_START_EN
    check("fs_bits", 65'(bus.false_start), 65'(2));
    check("fs_winner", 65'(bus.winner), 65'(1));
    check("fs_state", 65'(bus.state), 65'(3));
    check("fs_lights", 65'(bus.lights), 65'(0));
    do_start();
    ticks(30, "cd_abort");
`else
    check("fs_ignored", 65'({bus.state, bus.false_start}), 65'({2'd1, 2'd0}));
    ticks(19, "cd_nofs");
    check("nofs_race", 65'(bus.state), 65'(2));
`endif
    press(1, 0);
    do_tick("pre_abort");
    press(1, 0);
    do_tick("pre_abort");
    reset = 1'b0;
    @(negedge clk);
    model_reset();
    sb.push_back(snap_model());
    sb_check("abort");
    check("abort_state", 65'(bus.state), 65'(0));
    reset = 1'b1;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
